pulse_event_capture: RTL and testbench

- Sits downstream of pulse_stretcher, in the rd_clk domain, and consumes its stretched pulse_en level.
- Synchronizes the level, then measures each high interval: its start time and its width in rd_clk cycles.
- Queues one record per pulse in a small FIFO and presents records on a valid/ready interface to the rd-side consumer (CSR block or DMA).

---
 rtl/pulse_event_capture_if.sv | 25 ++
 rtl/pulse_event_capture.sv | 205 ++++++++++++++++++++
 tb/tb_pulse_event_capture.sv | 364 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pulse_event_capture_if.sv
// Record stream from pulse_event_capture to its rd-side consumer (CSR block or DMA).
// The producer drives valid/time/width; the consumer drives ready.
interface pulse_event_capture_if #(
    parameter int TS_W  = 32,
    parameter int WID_W = 16
);
    logic             evt_valid;
    logic             evt_ready;
    logic [TS_W-1:0]  evt_time;
    logic [WID_W-1:0] evt_width;

    modport master (
        output evt_valid,
        output evt_time,
        output evt_width,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_time,
        input  evt_width,
        output evt_ready
    );
endinterface

// File: rtl/pulse_event_capture.sv
// Synchronizes pulse_en, measures start time and width of each high interval, and queues one record per pulse in a FWFT FIFO.
// Optional macro PULSE_EVT_MIN_WIDTH_FILTER_EN drops records shorter than MIN_WIDTH and counts them in drop_cnt.
module pulse_event_capture #(
    parameter int SYNC_STAGES = 2,
    parameter int TS_W        = 32,
    parameter int WID_W       = 16,
    parameter int DEPTH       = 4,
    parameter int MIN_WIDTH   = 2
) (
    input  logic                   rd_clk,
    input  logic                   rd_resetn,
    input  logic                   pulse_en,
    input  logic                   clear_ovf,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                   overflow,
    output logic [7:0]             drop_cnt,
    pulse_event_capture_if.master  evt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int ARM_W = $clog2(SYNC_STAGES + 1);
    localparam int REC_W = TS_W + WID_W;

    if (SYNC_STAGES < 2 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || MIN_WIDTH < 1) begin : g_param_check
        $error("pulse_event_capture: illegal parameter set");
    end

    typedef enum logic [1:0] {
        ST_ARM  = 2'd0,
        ST_IDLE = 2'd1,
        ST_HIGH = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   s_d_q;
    logic [TS_W-1:0]        ts_q;
    logic [ARM_W-1:0]       arm_cnt_q;
    logic                   arm_filled;

    state_t                 state_q, state_d;
    logic [TS_W-1:0]        start_q, start_d;
    logic [WID_W-1:0]       width_q, width_d;
    logic                   rec_done;
    logic                   push;

    logic [REC_W-1:0]       mem_q [DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]       count_q, count_d;
    logic [LVL_W-1:0]       after_pop;
    logic                   full;
    logic                   pop;
    logic                   push_acc;
    logic                   drop;
    logic                   overflow_q, overflow_d;

    logic                   out_valid_q, out_valid_d;
    logic [TS_W-1:0]        out_time_q;
    logic [WID_W-1:0]       out_width_q;
    logic [REC_W-1:0]       head_rec;

    assign s = sync_q[SYNC_STAGES-1];
    // After reset the chain holds reset zeros rather than samples, so s=0 is only trusted once it has refilled.
    assign arm_filled = (arm_cnt_q == ARM_W'(SYNC_STAGES));

    always_ff @(posedge rd_clk) begin
        if (!rd_resetn) begin
            sync_q    <= '0;
            s_d_q     <= 1'b0;
            ts_q      <= '0;
            arm_cnt_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pulse_en};
            s_d_q  <= s;
            ts_q   <= ts_q + TS_W'(1);
            if (!arm_filled) begin
                arm_cnt_q <= arm_cnt_q + ARM_W'(1);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        start_d  = start_q;
        width_d  = width_q;
        rec_done = 1'b0;
        case (state_q)
            ST_ARM: begin
                if (arm_filled && !s) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (s && !s_d_q) begin
                    start_d = ts_q;
                    width_d = WID_W'(1);
                    state_d = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (s) begin
                    if (width_q != {WID_W{1'b1}}) begin
                        width_d = width_q + WID_W'(1);
                    end
                end else begin
                    rec_done = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_ARM;
        endcase
    end

    always_ff @(posedge rd_clk) begin
        if (!rd_resetn) begin
            state_q <= ST_ARM;
            start_q <= '0;
            width_q <= '0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            width_q <= width_d;
        end
    end

`ifdef PULSE_EVT_MIN_WIDTH_FILTER_EN
    localparam logic [WID_W:0] MIN_LIM = (WID_W + 1)'(MIN_WIDTH);
    logic       short_rec;
    logic [7:0] drop_cnt_q;

    assign short_rec = ({1'b0, width_q} < MIN_LIM);
    assign push      = rec_done && !short_rec;
    assign drop_cnt  = drop_cnt_q;

    always_ff @(posedge rd_clk) begin
        if (!rd_resetn) begin
            drop_cnt_q <= '0;
        end else if (rec_done && short_rec && drop_cnt_q != 8'hFF) begin
            drop_cnt_q <= drop_cnt_q + 8'd1;
        end
    end
`else
    assign push     = rec_done;
    assign drop_cnt = 8'd0;
`endif

    assign full     = (count_q == LVL_W'(DEPTH));
    assign pop      = out_valid_q && evt.evt_ready;
    assign push_acc = push && (!full || pop);
    assign drop     = push && full && !pop;

    // The output stage tracks the head as it stands before this edge's write, so a record pushed
    // into an empty FIFO shows up one cycle later and a pop immediately exposes the next stored entry.
    always_comb begin
        wr_ptr_d    = wr_ptr_q + PTR_W'(push_acc);
        rd_ptr_d    = rd_ptr_q + PTR_W'(pop);
        count_d     = count_q + LVL_W'(push_acc) - LVL_W'(pop);
        after_pop   = count_q - LVL_W'(pop);
        out_valid_d = (after_pop != '0);
        head_rec    = mem_q[rd_ptr_d];
        overflow_d  = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clear_ovf) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge rd_clk) begin
        if (push_acc) begin
            mem_q[wr_ptr_q] <= {start_q, width_q};
        end
    end

    always_ff @(posedge rd_clk) begin
        if (!rd_resetn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_time_q  <= '0;
            out_width_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            out_valid_q <= out_valid_d;
            if (out_valid_d) begin
                out_time_q  <= head_rec[REC_W-1:WID_W];
                out_width_q <= head_rec[WID_W-1:0];
            end
        end
    end

    assign evt.evt_valid = out_valid_q;
    assign evt.evt_time  = out_time_q;
    assign evt.evt_width = out_width_q;
    assign fifo_level    = count_q;
    assign overflow      = overflow_q;

endmodule

// File: tb/tb_pulse_event_capture.sv
// Randomized self-checking bench for pulse_event_capture against a record-level queue model.
module tb_pulse_event_capture;
    localparam int SYNC  = 2;
    localparam int DEPTH = 4;
    localparam int MINW  = 2;

    typedef struct packed {
        logic [31:0] t;
        logic [15:0] w;
    } rec_t;

    typedef struct packed {
        logic [7:0] t;
        logic [3:0] w;
    } rec_w_t;

    logic       rd_clk = 1'b0;
    logic       rd_resetn = 1'b0;
    logic       pulse_en = 1'b0;
    logic       pulse_w = 1'b0;
    logic       clear_ovf = 1'b0;
    logic [2:0] fifo_level, fifo_level_w;
    logic       overflow, overflow_w;
    logic [7:0] drop_cnt, drop_cnt_w;

    int     total = 0;
    int     bad = 0;
    longint cyc = 0;
    bit     rand_on = 1'b0;
    rec_t   exp_q[$];
    rec_t   got_q[$];
    rec_w_t got_w[$];

    pulse_event_capture_if #(.TS_W(32), .WID_W(16)) evt_if ();
    pulse_event_capture_if #(.TS_W(8), .WID_W(4)) evt_w ();

    pulse_event_capture #(.SYNC_STAGES(SYNC), .TS_W(32), .WID_W(16), .DEPTH(DEPTH), .MIN_WIDTH(MINW)) dut (
        .rd_clk(rd_clk), .rd_resetn(rd_resetn), .pulse_en(pulse_en), .clear_ovf(clear_ovf),
        .fifo_level(fifo_level), .overflow(overflow), .drop_cnt(drop_cnt), .evt(evt_if.master)
    );

    pulse_event_capture #(.SYNC_STAGES(SYNC), .TS_W(8), .WID_W(4), .DEPTH(DEPTH), .MIN_WIDTH(MINW)) dut_w (
        .rd_clk(rd_clk), .rd_resetn(rd_resetn), .pulse_en(pulse_w), .clear_ovf(1'b0),
        .fifo_level(fifo_level_w), .overflow(overflow_w), .drop_cnt(drop_cnt_w), .evt(evt_w.master)
    );

    always #5 rd_clk = ~rd_clk;

    // Cycle count since reset release; equals the spec's free-running timestamp.
    always @(posedge rd_clk) cyc <= rd_resetn ? cyc + 1 : 0;

    always @(negedge rd_clk) begin
        if (rd_resetn && evt_if.evt_valid && evt_if.evt_ready) got_q.push_back({evt_if.evt_time, evt_if.evt_width});
        if (rd_resetn && evt_w.evt_valid && evt_w.evt_ready) got_w.push_back({evt_w.evt_time, evt_w.evt_width});
    end

    function automatic rec_t mk_rec(longint t0, int w);
        rec_t r;
        r.t = 32'(t0 + SYNC);
        r.w = (w > 65535) ? 16'hFFFF : 16'(w);
        return r;
    endfunction

    function automatic bit kept(int w);
`ifdef PULSE_EVT_MIN_WIDTH_FILTER_EN
        return w >= MINW;
`else
        return (w >= 1);
`endif
    endfunction

    task automatic tick;
        @(posedge rd_clk);
        #1;
    endtask

    task automatic pulse(input int w, output longint t0);
        tick;
        t0 = cyc;
        pulse_en = 1'b1;
        repeat (w) tick;
        pulse_en = 1'b0;
    endtask

    task automatic settle;
        repeat (SYNC + 4) tick;
    endtask

    task automatic drain;
        int n;
        n = 0;
        evt_if.evt_ready = 1'b1;
        while (fifo_level != 3'd0 && n < 60) begin
            tick;
            n++;
        end
        tick;
        evt_if.evt_ready = 1'b0;
    endtask

    task automatic do_reset;
        rd_resetn = 1'b0;
        pulse_en = 1'b0;
        pulse_w = 1'b0;
        repeat (3) tick;
        rd_resetn = 1'b1;
        exp_q.delete();
        got_q.delete();
        got_w.delete();
        repeat (SYNC + 3) tick;
    endtask

    task automatic test_reset;
        longint t0;
        rec_t g;
        rd_resetn = 1'b0;
        pulse_en = 1'b1;
        repeat (3) tick;
        total++; if (evt_if.evt_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %0d want 0", evt_if.evt_valid); end
        total++; if (fifo_level !== 3'd0) begin bad++; $display("FAIL rst_level: got %0d want 0", fifo_level); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst_overflow: got %0d want 0", overflow); end
        total++; if (drop_cnt !== 8'd0) begin bad++; $display("FAIL rst_drop_cnt: got %0d want 0", drop_cnt); end
        total++; if (evt_if.evt_time !== 32'd0) begin bad++; $display("FAIL rst_time: got %0d want 0", evt_if.evt_time); end
        total++; if (evt_if.evt_width !== 16'd0) begin bad++; $display("FAIL rst_width: got %0d want 0", evt_if.evt_width); end
        rd_resetn = 1'b1;
        repeat (20) tick;
        pulse_en = 1'b0;
        repeat (10) tick;
        total++; if (fifo_level !== 3'd0 || got_q.size() != 0) begin bad++; $display("FAIL arm_ignore: got level %0d recs %0d want 0 0", fifo_level, got_q.size()); end
        pulse(5, t0);
        exp_q.push_back(mk_rec(t0, 5));
        settle;
        drain;
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL reset_rec_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            g = '0; if (i < got_q.size()) g = got_q[i];
            total++; if (g !== exp_q[i]) begin bad++; $display("FAIL reset_rec[%0d]: got t=%0d w=%0d want t=%0d w=%0d", i, g.t, g.w, exp_q[i].t, exp_q[i].w); end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_latency_order;
        longint ta, tb_t;
        int n;
        rec_t g;
        logic [31:0] diff;
        evt_if.evt_ready = 1'b1;
        pulse(3, ta);
        exp_q.push_back(mk_rec(ta, 3));
        n = 0;
        while (!evt_if.evt_valid && n < 20) begin tick; n++; end
        total++; if (n != SYNC + 2) begin bad++; $display("FAIL latency_a: got %0d want %0d", n, SYNC + 2); end
        while (cyc + 1 != ta + 40) tick;
        pulse(7, tb_t);
        exp_q.push_back(mk_rec(tb_t, 7));
        n = 0;
        while (!evt_if.evt_valid && n < 20) begin tick; n++; end
        total++; if (n != SYNC + 2) begin bad++; $display("FAIL latency_b: got %0d want %0d", n, SYNC + 2); end
        settle;
        diff = 32'hFFFF_FFFF;
        if (got_q.size() >= 2) diff = got_q[1].t - got_q[0].t;
        total++; if (diff !== 32'd40) begin bad++; $display("FAIL time_delta: got %0d want 40", diff); end
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL order_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            g = '0; if (i < got_q.size()) g = got_q[i];
            total++; if (g !== exp_q[i]) begin bad++; $display("FAIL order_rec[%0d]: got t=%0d w=%0d want t=%0d w=%0d", i, g.t, g.w, exp_q[i].t, exp_q[i].w); end
        end
        evt_if.evt_ready = 1'b0;
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_overflow;
        longint t0;
        int w;
        rec_t g;
        evt_if.evt_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            w = int'($urandom_range(2, 9));
            pulse(w, t0);
            if (exp_q.size() < DEPTH) exp_q.push_back(mk_rec(t0, w));
            repeat ($urandom_range(3, 8)) tick;
        end
        settle;
        total++; if (fifo_level !== 3'd4) begin bad++; $display("FAIL ovf_level: got %0d want 4", fifo_level); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set: got %0d want 1", overflow); end
        pulse(4, t0);
        repeat (SYNC) tick;
        clear_ovf = 1'b1;
        tick;
        clear_ovf = 1'b0;
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set_wins: got %0d want 1", overflow); end
        total++; if (fifo_level !== 3'd4) begin bad++; $display("FAIL ovf_level_after_drop: got %0d want 4", fifo_level); end
        clear_ovf = 1'b1;
        tick;
        clear_ovf = 1'b0;
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear: got %0d want 0", overflow); end
        drain;
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL ovf_rec_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            g = '0; if (i < got_q.size()) g = got_q[i];
            total++; if (g !== exp_q[i]) begin bad++; $display("FAIL ovf_rec[%0d]: got t=%0d w=%0d want t=%0d w=%0d", i, g.t, g.w, exp_q[i].t, exp_q[i].w); end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_full_push_pop;
        longint t0;
        int w;
        rec_t g;
        for (int i = 0; i < DEPTH; i++) begin
            w = int'($urandom_range(2, 6));
            pulse(w, t0);
            exp_q.push_back(mk_rec(t0, w));
            repeat (4) tick;
        end
        settle;
        total++; if (fifo_level !== 3'd4) begin bad++; $display("FAIL fpp_level_full: got %0d want 4", fifo_level); end
        pulse(5, t0);
        exp_q.push_back(mk_rec(t0, 5));
        repeat (SYNC) tick;
        evt_if.evt_ready = 1'b1;
        tick;
        evt_if.evt_ready = 1'b0;
        total++; if (fifo_level !== 3'd4) begin bad++; $display("FAIL fpp_level: got %0d want 4", fifo_level); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL fpp_overflow: got %0d want 0", overflow); end
        settle;
        drain;
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL fpp_rec_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            g = '0; if (i < got_q.size()) g = got_q[i];
            total++; if (g !== exp_q[i]) begin bad++; $display("FAIL fpp_rec[%0d]: got t=%0d w=%0d want t=%0d w=%0d", i, g.t, g.w, exp_q[i].t, exp_q[i].w); end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_filter;
        longint t0;
        int widths[3];
        int drops;
        rec_t g;
        widths = '{1, 1, 2};
        drops = 0;
        do_reset;
        foreach (widths[i]) begin
            pulse(widths[i], t0);
            if (kept(widths[i])) exp_q.push_back(mk_rec(t0, widths[i]));
            else drops++;
            repeat (6) tick;
        end
        settle;
        total++; if (drop_cnt !== 8'(drops)) begin bad++; $display("FAIL filter_drop_cnt: got %0d want %0d", drop_cnt, drops); end
        total++; if (fifo_level !== 3'(exp_q.size())) begin bad++; $display("FAIL filter_level: got %0d want %0d", fifo_level, exp_q.size()); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL filter_overflow: got %0d want 0", overflow); end
        drain;
        foreach (exp_q[i]) begin
            g = '0; if (i < got_q.size()) g = got_q[i];
            total++; if (g !== exp_q[i]) begin bad++; $display("FAIL filter_rec[%0d]: got t=%0d w=%0d want t=%0d w=%0d", i, g.t, g.w, exp_q[i].t, exp_q[i].w); end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_random;
        rec_t g;
        do_reset;
        rand_on = 1'b1;
        fork
            begin
                longint t0;
                int w;
                for (int i = 0; i < 12; i++) begin
                    w = int'($urandom_range(1, 12));
                    pulse(w, t0);
                    if (kept(w)) exp_q.push_back(mk_rec(t0, w));
                    repeat ($urandom_range(12, 20)) tick;
                end
                rand_on = 1'b0;
            end
            begin
                while (rand_on) begin
                    evt_if.evt_ready = 1'($urandom_range(0, 1));
                    tick;
                end
                evt_if.evt_ready = 1'b0;
            end
        join
        settle;
        drain;
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rand_overflow: got %0d want 0", overflow); end
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL rand_rec_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            g = '0; if (i < got_q.size()) g = got_q[i];
            total++; if (g !== exp_q[i]) begin bad++; $display("FAIL rand_rec[%0d]: got t=%0d w=%0d want t=%0d w=%0d", i, g.t, g.w, exp_q[i].t, exp_q[i].w); end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_saturate;
        longint t0;
        rec_t g;
        rec_t e;
        evt_if.evt_ready = 1'b1;
        pulse(70000, t0);
        e = mk_rec(t0, 70000);
        settle;
        evt_if.evt_ready = 1'b0;
        g = '0; if (got_q.size() > 0) g = got_q[0];
        total++; if (got_q.size() != 1) begin bad++; $display("FAIL sat_count: got %0d want 1", got_q.size()); end
        total++; if (g !== e) begin bad++; $display("FAIL sat_rec: got t=%0d w=%0d want t=%0d w=%0d", g.t, g.w, e.t, e.w); end
        got_q.delete();
    endtask

    task automatic test_wrap;
        longint t0;
        rec_w_t e[2];
        rec_w_t g;
        int wid[2];
        int tgt[2];
        wid = '{20, 3};
        tgt = '{254, 0};
        do_reset;
        evt_w.evt_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            while (((cyc + 2 + SYNC) & 255) != longint'(tgt[k])) tick;
            tick;
            t0 = cyc;
            pulse_w = 1'b1;
            repeat (wid[k]) tick;
            pulse_w = 1'b0;
            e[k].t = 8'(t0 + SYNC);
            e[k].w = (wid[k] > 15) ? 4'hF : 4'(wid[k]);
            settle;
        end
        total++; if (got_w.size() != 2) begin bad++; $display("FAIL wrap_count: got %0d want 2", got_w.size()); end
        for (int k = 0; k < 2; k++) begin
            g = '0; if (k < got_w.size()) g = got_w[k];
            total++; if (g !== e[k]) begin bad++; $display("FAIL wrap_rec[%0d]: got t=%0d w=%0d want t=%0d w=%0d", k, g.t, g.w, e[k].t, e[k].w); end
        end
        total++; if (overflow_w !== 1'b0 || fifo_level_w !== 3'd0 || drop_cnt_w !== 8'd0) begin
            bad++; $display("FAIL wrap_status: got ovf=%0d lvl=%0d drop=%0d want 0 0 0", overflow_w, fifo_level_w, drop_cnt_w);
        end
        got_w.delete();
    endtask

    initial begin
        evt_if.evt_ready = 1'b0;
        evt_w.evt_ready = 1'b0;
        test_reset;
        test_latency_order;
        test_overflow;
        test_full_push_pop;
        test_filter;
        test_random;
        test_saturate;
        test_wrap;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout: simulation did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end
endmodule
